// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a byte-wide data memory, branch resolve,
// and a MEM_WB register. After reset the memory is cleared one byte per cycle
// (INIT) before normal accesses are accepted (RUN).
// Optional macro MEM_STAGE_ACCESS_CNT_EN adds saturating load/store counters.
module mem_stage #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WB_in,
  input  logic [3:0]  M_in,
  input  logic [31:0] branch_addr_in,
  input  logic        zero_in,
  input  logic [7:0]  ALUOut_in,
  input  logic [7:0]  read_data2_in,
  input  logic [4:0]  rd_in,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic        busy,
  output logic [1:0]  WB_out,
  output logic [7:0]  mem_data_out,
  output logic [7:0]  ALUOut_out,
  output logic [4:0]  rd_out
`ifdef MEM_STAGE_ACCESS_CNT_EN
  ,
  output logic [15:0] load_count,
  output logic [15:0] store_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic              run;
  logic              mem_we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  assign addr          = ALUOut_in[ADDR_W-1:0];
  assign run           = (state_q == RUN);
  assign busy          = (state_q == INIT);
  assign PCSrc         = M_in[3] & (zero_in ^ M_in[2]);
  assign branch_target = branch_addr_in;

  // State and init-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and memory write port selection (init clear vs. store)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    waddr   = addr;
    wdata   = read_data2_in;
    case (state_q)
      INIT: begin
        mem_we = 1'b1;
        waddr  = cnt_q;
        wdata  = 8'h00;
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        mem_we = M_in[0];
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
    if (rst) mem_we = 1'b0;
  end

  // Data memory write port; reads below see the pre-write byte
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
  end

  // MEM_WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_out       <= '0;
      mem_data_out <= '0;
      ALUOut_out   <= '0;
      rd_out       <= '0;
    end else begin
      WB_out       <= {WB_in[1], WB_in[0] & run};
      mem_data_out <= (run && M_in[1]) ? mem[addr] : 8'h00;
      ALUOut_out   <= ALUOut_in;
      rd_out       <= rd_in;
    end
  end

`ifdef MEM_STAGE_ACCESS_CNT_EN
  // Saturating access counters, RUN-state accesses only
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (run && M_in[1] && (load_count != 16'hFFFF))
        load_count <= load_count + 16'd1;
      if (run && M_in[0] && (store_count != 16'hFFFF))
        store_count <= store_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameters: DEPTH, default 256, number of data-memory bytes (power of two, max 256); ADDR_W, default 8, address bits used from ALUOut_in.
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have: WB_in  input  2  writeback controls from EX_MEM; bit0 RegWrite, bit1 MemtoReg.
REQ-005 SHALL have: M_in  input  4  memory controls from EX_MEM; bit0 MemWrite, bit1 MemRead, bit2 BranchFlip, bit3 Branch.
REQ-006 SHALL have: branch_addr_in  input  32  branch target from EX_MEM.
REQ-007 SHALL have: zero_in  input  1  ALU zero flag from EX_MEM.
REQ-008 SHALL have: ALUOut_in  input  8  ALU result and memory address.
REQ-009 SHALL have: read_data2_in  input  8  store data.
REQ-010 SHALL have: rd_in  input  5  destination register.
REQ-011 SHALL have: PCSrc  output  1  branch taken, combinational.
REQ-012 SHALL have: branch_target  output  32  equals branch_addr_in, combinational.
REQ-013 SHALL have: busy  output  1  high while memory initialisation runs.
REQ-014 SHALL have: WB_out 2, mem_data_out 8, ALUOut_out 8, rd_out 5  outputs  registered MEM_WB stage values.

Function
REQ-015 SHALL hold an internal DEPTH x 8 data memory addressed by ALUOut_in[ADDR_W-1:0].
REQ-016 SHALL drive PCSrc = M_in[3] AND (zero_in XOR M_in[2]) with zero cycles of latency.
REQ-017 SHALL, in RUN state with M_in[0]=1, write read_data2_in to the addressed byte on the rising edge.
REQ-018 SHALL, in RUN state with M_in[1]=1, register the addressed byte into mem_data_out on the rising edge (latency one cycle); with M_in[1]=0 it SHALL register 0.
REQ-019 SHALL, when M_in[0] and M_in[1] are both high for the same address, return the pre-write byte (read-before-write).
REQ-020 SHALL register WB_in, ALUOut_in, rd_in into WB_out, ALUOut_out, rd_out every cycle (latency one cycle), in both states.
REQ-021 SHALL implement FSM states INIT and RUN; INIT clears one byte per cycle using an ADDR_W-bit counter from 0 upward.
REQ-022 SHALL transition INIT -> RUN on the cycle after the counter reaches DEPTH-1; counter wraps to 0.
REQ-023 SHALL, in INIT, ignore stores, force mem_data_out to 0, and force WB_out[0] (RegWrite) to 0.
REQ-024 SHALL drive busy=1 exactly in INIT; INIT lasts DEPTH cycles.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, enter INIT, zero the init counter, and zero WB_out, mem_data_out, ALUOut_out, rd_out.
REQ-026 SHALL, on rst asserted mid-INIT or mid-RUN, restart initialisation from address 0; no store occurs on a reset cycle.

Configuration
REQ-027 SHALL provide macro MEM_STAGE_ACCESS_CNT_EN; when defined, adds outputs load_count[15:0] and store_count[15:0].
REQ-028 SHALL, with macro defined, increment load_count per RUN cycle with MemRead=1 and store_count per RUN cycle with MemWrite=1, saturating at 0xFFFF, zeroed by rst.
REQ-029 SHALL, without macro, have no counter ports or logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: rst pulse -> busy=1 for 256 cycles, then 0; all registered outputs 0 during reset.
REQ-031 SHALL cover: RUN, store 0xA5 at 0x10, then load 0x10 -> mem_data_out=0xA5 one cycle after load.
REQ-032 SHALL cover: Branch=1, BranchFlip=0, zero=1 -> PCSrc=1; BranchFlip=1 zero=1 -> PCSrc=0; Branch=0 -> PCSrc=0.
REQ-033 SHALL cover: byte 0x20=0x11, simultaneous load and store 0x22 at 0x20 -> mem_data_out=0x11, next load -> 0x22.
REQ-034 SHALL cover: store during INIT at 0x05 -> after RUN, load 0x05 -> 0x00; WB_out[0]=0 throughout INIT.
REQ-035 SHALL cover: rst at cycle 100 of INIT -> busy remains high 256 further cycles; with MEM_STAGE_ACCESS_CNT_EN, 3 loads and 2 stores -> counts 3 and 2.
